prog_rom: RTL and testbench
===========================

# prog_rom

Parametrised, byte-programmable instruction store for the model computer's fetch stage. Holds 2^ADDR_W bytes, returns BYTES consecutive bytes per fetch as one opcode word with wrap-around, and accepts single-byte writes from the front-panel edit interface. On every reset release it restores the default program image by walking the whole array before it serves fetches.

## Interface
- ADDR_W, 8, byte address width; DEPTH = 2^ADDR_W bytes
- BYTES, 4, bytes per fetched opcode (1..8)
- BOOT_SIZE, 16, write-protected low region size in bytes (used only with PROG_ROM_WPROT_EN)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- edit  in  1  programming mode select
- unit  in  ADDR_W  byte address to program
- code  in  8  byte to program
- send  in  1  write strobe, rising-edge triggered
- address  in  ADDR_W  fetch address
- opcode  out  8*BYTES  fetched word; mem[address] in MSBs
- valid  out  1  opcode reflects a completed fetch
- busy  out  1  restore in progress
- ack  out  1  one-cycle pulse: byte write committed
- err  out  1  one-cycle pulse: write rejected (only with PROG_ROM_WPROT_EN)

## Operation
- States: RESTORE, RUN, EDIT.
- RESTORE: entered on reset release; counter ptr 0..DEPTH-1 writes prog_rom_pkg::default_byte(ptr), one byte per cycle; busy=1, valid=0; edit/send/address ignored; on ptr=DEPTH-1 go RUN.
- RUN (edit=0): each cycle opcode byte i <= mem[(address+i) mod DEPTH], i=0 at MSBs; valid=1.
- EDIT (edit=1, not busy): fetch suspended, opcode holds last value, valid=0. Rising edge of send (send=1, send_q=0) writes code to mem[unit]; ack pulses. Held send writes once only.
- RUN<->EDIT follows edit each cycle; no other conditions.
- send_q samples send every cycle in all states; an edge seen during RESTORE or RUN is discarded, not queued. send already high when edit rises produces no write.
- Address arithmetic modulo DEPTH: address=DEPTH-1 with BYTES=4 returns mem[DEPTH-1], mem[0], mem[1], mem[2].

## Timing
- Reset values: opcode=0, valid=0, ack=0, err=0, busy=1, state=RESTORE, ptr=0, send_q=0. Array not cleared by reset; restored by RESTORE.
- Restore latency: busy falls DEPTH cycles after first rising clk with rst=1; first valid fetch one cycle later.
- Fetch latency: 1 cycle; address sampled at edge k appears on opcode after edge k.
- Write: send edge sampled at edge k commits at edge k; ack=1 for cycle after edge k; byte visible to a fetch sampled at edge k+1 (requires edit=0 by then).
- Reset asserted mid-restore or mid-edit: outputs go to reset values immediately; in-flight write lost; restore restarts from ptr=0.

## Configuration
- PROG_ROM_WPROT_EN defined: writes with unit < BOOT_SIZE are rejected; array unchanged, err pulses instead of ack, same timing; err port present.
- Undefined: all addresses writable; err port absent; BOOT_SIZE unused.

## Structure
- prog_rom_pkg: state enum (RESTORE, RUN, EDIT), BYTE_W=8, default_byte(addr) function defining the boot image (addr 0..3 = 8'h01, 8'h02, 8'h03, 8'h04; all others 8'h00).
- Sub-module prog_rom_restore: ptr counter, done flag, restore write port; top holds array, FSM, edge detect, fetch register.

## Test plan
- Reset pulse, hold address=0 -> busy high for DEPTH cycles, then opcode=32'h01020304, valid=1.
- edit=1, unit=8'h04..8'h07, code=FF,00,1F,02, one send pulse each -> four ack pulses; edit=0, address=8'h04 -> opcode=32'hFF001F02 next cycle.
- send held high 10 cycles in EDIT with code changing -> exactly one write, one ack.
- address=8'hFF after restore -> opcode=32'h00010203 (wrap).
- Reset asserted mid-edit, then address=8'h04 after restore -> opcode=32'h00000000 (edits discarded by restore).
- PROG_ROM_WPROT_EN: write unit=8'h02 -> err pulse, no ack, mem[2] stays 8'h03; unit=8'h20 -> ack.

Source files
------------

// File: rtl/prog_rom_pkg.sv
// prog_rom_pkg: shared state type, byte width and the boot image used by prog_rom.
package prog_rom_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {RESTORE, RUN, EDIT} state_t;
  function automatic logic [BYTE_W-1:0] default_byte(input int unsigned addr);
    return (addr < 4) ? BYTE_W'(addr + 1) : '0;
  endfunction
endpackage

// File: rtl/prog_rom_restore.sv
// prog_rom_restore: walks every byte address after reset, supplying the boot image byte for each.
module prog_rom_restore
  import prog_rom_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_ptr,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_done
);
  logic [ADDR_W-1:0] r_ptr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_ptr <= '0;
    else if (i_en) r_ptr <= r_ptr + ADDR_W'(1);
  assign o_ptr  = r_ptr;
  assign o_data = default_byte(32'(r_ptr));
  assign o_done = &r_ptr;
endmodule

// File: rtl/prog_rom.sv
// prog_rom: byte-programmable opcode store with boot-image restore and wrap-around multi-byte fetch.
// Optional write protection of the low BOOT_SIZE bytes is enabled by defining PROG_ROM_WPROT_EN.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BYTES     = 4,
  parameter int BOOT_SIZE = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_edit,
  input  logic [ADDR_W-1:0]       i_unit,
  input  logic [BYTE_W-1:0]       i_code,
  input  logic                    i_send,
  input  logic [ADDR_W-1:0]       i_address,
  output logic [BYTE_W*BYTES-1:0] o_opcode,
  output logic                    o_valid,
  output logic                    o_busy,
`ifdef PROG_ROM_WPROT_EN
  output logic                    o_err,
`endif
  output logic                    o_ack
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t                    r_state, w_next;
  logic                      r_send_q, r_valid, r_ack;
  logic [BYTE_W*BYTES-1:0]   r_opcode, w_fetch;
  logic [BYTE_W-1:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]         w_ptr, w_waddr;
  logic [ADDR_W-1:0]         w_idx [BYTES];
  logic [BYTE_W-1:0]         w_rdata, w_wdata;
  logic                      w_done, w_busy, w_wr, w_prot, w_we;
  prog_rom_restore #(.ADDR_W(ADDR_W)) u_restore (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (w_busy),
    .o_ptr  (w_ptr),
    .o_data (w_rdata),
    .o_done (w_done)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= RESTORE;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == RESTORE) ? (w_done ? RUN : RESTORE) : (i_edit ? EDIT : RUN);
  end
  assign w_busy = r_state == RESTORE;
  // Only a fresh rising edge of send, seen while already in EDIT, is a write.
  assign w_wr   = (r_state == EDIT) & i_send & ~r_send_q;
`ifdef PROG_ROM_WPROT_EN
  assign w_prot = 32'(i_unit) < 32'(BOOT_SIZE);
`else
  assign w_prot = 1'b0;
`endif
  assign w_we    = w_busy | (w_wr & ~w_prot);
  assign w_waddr = w_busy ? w_ptr : i_unit;
  assign w_wdata = w_busy ? w_rdata : i_code;
  always_ff @(posedge i_clk)
    if (w_we) r_mem[w_waddr] <= w_wdata;
  for (genvar g = 0; g < BYTES; g++) begin : g_fetch
    assign w_idx[g] = i_address + ADDR_W'(g);
    assign w_fetch[BYTE_W*(BYTES-1-g) +: BYTE_W] = r_mem[w_idx[g]];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_send_q <= 1'b0;
      r_valid  <= 1'b0;
      r_ack    <= 1'b0;
      r_opcode <= '0;
    end else begin
      r_send_q <= i_send;
      r_valid  <= r_state == RUN;
      r_ack    <= w_wr & ~w_prot;
      if (r_state == RUN) r_opcode <= w_fetch;
    end
`ifdef PROG_ROM_WPROT_EN
  logic r_err;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_err <= 1'b0;
    else r_err <= w_wr & w_prot;
  assign o_err = r_err;
`endif
  assign o_opcode = r_opcode;
  assign o_valid  = r_valid;
  assign o_ack    = r_ack;
  assign o_busy   = w_busy;
endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: randomized scoreboard bench for prog_rom against a byte-array reference model.
module tb_prog_rom;
  localparam int ADDR_W = 8;
  localparam int BYTES  = 4;
  localparam int DEPTH  = 256;
  localparam int BOOT   = 16;
`ifdef PROG_ROM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, edit = 1'b0, send = 1'b0;
  logic [7:0]  unit = '0, code = '0, address = '0;
  logic [31:0] opcode;
  logic        valid, busy, ack, err;
  always #5 clk = ~clk;

  prog_rom #(.ADDR_W(ADDR_W), .BYTES(BYTES), .BOOT_SIZE(BOOT)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_edit   (edit),
    .i_unit   (unit),
    .i_code   (code),
    .i_send   (send),
    .i_address(address),
    .o_opcode (opcode),
    .o_valid  (valid),
    .o_busy   (busy),
`ifdef PROG_ROM_WPROT_EN
    .o_err    (err),
`endif
    .o_ack    (ack)
  );
`ifndef PROG_ROM_WPROT_EN
  assign err = 1'b0;
`endif

  typedef enum {M_RST, M_RUN, M_EDIT} mstate_t;
  logic [7:0]  mem_m [DEPTH];
  mstate_t     mst = M_RST;
  int          rcnt = 0;
  bit          send_prev = 1'b0;
  logic [31:0] exp_q [$];
  logic [1:0]  ev_q [$];
  int          n_cmp = 0, n_bad = 0, n_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_fetch(input int a);
    logic [31:0] r = '0;
    for (int i = 0; i < BYTES; i++) r = {r[23:0], mem_m[(a + i) % DEPTH]};
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model over the coming edge, then settle past the next negedge.
  task automatic step(input bit e, input bit s, input logic [7:0] u, input logic [7:0] c, input logic [7:0] a);
    edit = e; send = s; unit = u; code = c; address = a;
    if (mst == M_RST) begin
      mem_m[rcnt] = (rcnt < 4) ? 8'(rcnt + 1) : 8'h00;
      rcnt++;
      if (rcnt == DEPTH) mst = M_RUN;
    end else if (mst == M_RUN) begin
      exp_q.push_back(model_fetch(int'(a)));
      mst = e ? M_EDIT : M_RUN;
    end else begin
      if (s && !send_prev) begin
        if (WPROT && int'(u) < BOOT) ev_q.push_back(2'b01);
        else begin
          mem_m[u] = c;
          ev_q.push_back(2'b10);
        end
      end
      mst = e ? M_EDIT : M_RUN;
    end
    send_prev = s;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_opcode", opcode, 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h1);
    check("reset_ack", 32'({ack, err}), 32'h0);
    check("pending_fetch_at_reset", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    ev_q.delete();
    mst = M_RST; rcnt = 0; send_prev = 1'b0;
    edit = 1'b0; send = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic restore();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      if (i == DEPTH - 2) check("busy_during_restore", 32'(busy), 32'h1);
    end
    check("busy_after_restore", 32'(busy), 32'h0);
    check("valid_after_restore", 32'(valid), 32'h0);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) check("fetch_unexpected_valid", 32'(valid), 32'h0);
      else check("fetch", opcode, exp_q.pop_front());
    end
    if (ack || err) begin
      if (ev_q.size() == 0) check("write_resp_unexpected", 32'({ack, err}), 32'h0);
      else check("write_resp", 32'({ack, err}), 32'(ev_q.pop_front()));
    end
    if (ack) n_ack++;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] units [4];
    logic [7:0] codes [4];
    int a0;
    units = '{8'h04, 8'h05, 8'h06, 8'h07};
    codes = '{8'hFF, 8'h00, 8'h1F, 8'h02};
    do_reset();
    restore();
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("boot_word", opcode, 32'h01020304);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);
    check("wrap_word", opcode, 32'h00010203);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    a0 = n_ack;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, units[i], codes[i], 8'h00);
      step(1'b1, 1'b0, units[i], codes[i], 8'h00);
    end
    check("edit_acks", 32'(n_ack - a0), 32'd4);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
    check("edited_word", opcode, 32'hFF001F02);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    a0 = n_ack;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h40, 8'($urandom), 8'h00);
    step(1'b1, 1'b0, 8'h40, 8'h00, 8'h00);
    check("held_send_acks", 32'(n_ack - a0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h40);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h3E);
`ifdef PROG_ROM_WPROT_EN
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    a0 = n_ack;
    step(1'b1, 1'b1, 8'h02, 8'hAA, 8'h00);
    step(1'b1, 1'b0, 8'h02, 8'hAA, 8'h00);
    check("prot_no_ack", 32'(n_ack - a0), 32'd0);
    step(1'b1, 1'b1, 8'h20, 8'h55, 8'h00);
    step(1'b1, 1'b0, 8'h20, 8'h55, 8'h00);
    check("unprot_ack", 32'(n_ack - a0), 32'd1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("prot_boot_word", opcode, 32'h01020304);
`endif
    // send already high when edit rises must not write
    step(1'b0, 1'b1, 8'h50, 8'h77, 8'h00);
    step(1'b1, 1'b1, 8'h50, 8'h77, 8'h00);
    step(1'b1, 1'b1, 8'h50, 8'h77, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h50);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h50);
    check("no_write_on_held_send", opcode, 32'h00000000);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 9) < 4, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b1, 8'h04, 8'hAA, 8'h00);
    send = 1'b1;
    do_reset();
    restore();
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
    check("after_reset_word", opcode, 32'h00000000);
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    do_reset();
    restore();
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("restart_boot_word", opcode, 32'h01020304);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'($urandom));
    check("fetch_queue_drained", 32'(exp_q.size()), 32'h0);
    check("resp_queue_drained", 32'(ev_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
